// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared packet types, widths and FSM states for the memory request arbiter
package mem_req_arbiter_pkg;

  localparam int SLOT_W = 4;
  localparam int ADDR_W = 36;
  localparam int OUT_W  = 5;

  localparam logic [2:0] PKT_IDLE    = 3'b000;
  localparam logic [2:0] PKT_WR      = 3'b001;
  localparam logic [2:0] PKT_RD      = 3'b011;
  localparam logic [2:0] PKT_WR_ACK  = 3'b101;
  localparam logic [2:0] PKT_RD_DATA = 3'b110;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - requester, controller and flush signals of the memory request arbiter
interface mem_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 512
);
  import mem_req_arbiter_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DEPTH-1:0]  req_data;

  slot_t                          mc_id_out;
  logic [2:0]                     mc_type_out;
  logic [ADDR_W-1:0]              mc_addr_out;
  logic [DEPTH-1:0]               mc_data_out;

  slot_t                          mc_id_in;
  logic [2:0]                     mc_type_in;
  logic [ADDR_W-1:0]              mc_addr_in;
  logic [DEPTH-1:0]               mc_data_in;

  logic [NUM_REQ-1:0]             rsp_valid;
  logic                           rsp_write;
  logic [ADDR_W-1:0]              rsp_addr;
  logic [DEPTH-1:0]               rsp_data;

  logic                           flush;
  logic                           flush_done;
  logic                           err_order;

  modport slave (
    input  req_valid, req_write, req_addr, req_data,
    input  mc_id_in, mc_type_in, mc_addr_in, mc_data_in, flush,
    output req_ready, mc_id_out, mc_type_out, mc_addr_out, mc_data_out,
    output rsp_valid, rsp_write, rsp_addr, rsp_data, flush_done, err_order
  );

  modport master (
    output req_valid, req_write, req_addr, req_data,
    output mc_id_in, mc_type_in, mc_addr_in, mc_data_in, flush,
    input  req_ready, mc_id_out, mc_type_out, mc_addr_out, mc_data_out,
    input  rsp_valid, rsp_write, rsp_addr, rsp_data, flush_done, err_order
  );

endinterface

// File: rtl/mem_req_arbiter_rr_picker.sv
// rtl/mem_req_arbiter_rr_picker.sv - round-robin picker: first set request at or after ptr, one-hot grant
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               found
);

  logic [IDX_W:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // wrap manually so non-power-of-two requester counts stay in range
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin arbiter issuing tagged requests to the memory controller
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 512,
  parameter int SLOTS   = 16
) (
  input logic                clk,
  input logic                rst_n,
  mem_req_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  slot_t              head, tail;
  logic [OUT_W-1:0]   outstanding;
  logic [IDX_W-1:0]   tag [SLOTS];
  logic [SLOTS-1:0]   wr;
  logic               issue_q;

  logic               grant_en, found, rsp_in, rsp_ok, done_enter;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gidx;

  // the rst_n term keeps req_ready low while reset is held, not just after it
  assign grant_en = rst_n && (state == RUN) && !bus.flush && (outstanding < OUT_W'(SLOTS));

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req       (bus.req_valid & {NUM_REQ{grant_en}}),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (gidx),
    .found     (found)
  );

  assign bus.req_ready = grant;

  assign rsp_in = (bus.mc_type_in == PKT_WR_ACK) || (bus.mc_type_in == PKT_RD_DATA);
  assign rsp_ok = rsp_in && (bus.mc_id_in == head) && (outstanding != '0);

  // the slot just issued is still the one named by mc_id_out, so its wr bit gives the type
  assign bus.mc_type_out = issue_q ? (wr[bus.mc_id_out] ? PKT_WR : PKT_RD) : PKT_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    done_enter = 1'b0;
    case (state)
      RUN:   if (bus.flush) state_nxt = DRAIN;
      DRAIN: if (outstanding == '0 && !found) begin
               state_nxt  = DONE;
               done_enter = 1'b1;
             end
      DONE:  if (!bus.flush) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr          <= '0;
      head            <= '0;
      tail            <= '0;
      outstanding     <= '0;
      wr              <= '0;
      issue_q         <= 1'b0;
      for (int s = 0; s < SLOTS; s++) tag[s] <= '0;
      bus.mc_id_out   <= '0;
      bus.mc_addr_out <= '0;
      bus.mc_data_out <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_write   <= 1'b0;
      bus.rsp_addr    <= '0;
      bus.rsp_data    <= '0;
      bus.flush_done  <= 1'b0;
      bus.err_order   <= 1'b0;
    end else begin
      issue_q        <= found;
      bus.flush_done <= done_enter;
      if (found) begin
        rr_ptr          <= (gidx == IDX_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
        tag[tail]       <= gidx;
        wr[tail]        <= bus.req_write[gidx];
        tail            <= tail + 1'b1;
        bus.mc_id_out   <= tail;
        bus.mc_addr_out <= bus.req_addr[gidx];
        bus.mc_data_out <= bus.req_data[gidx];
      end
      bus.rsp_valid <= '0;
      if (rsp_ok) begin
        bus.rsp_valid <= NUM_REQ'(1) << tag[head];
        bus.rsp_write <= (bus.mc_type_in == PKT_WR_ACK);
        bus.rsp_addr  <= bus.mc_addr_in;
        bus.rsp_data  <= bus.mc_data_in;
        head          <= head + 1'b1;
      end else if (rsp_in) begin
        bus.err_order <= 1'b1;
      end
      case ({found, rsp_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench: vector table, corner sequences, randomized reference model
module tb_mem_req_arbiter;

  localparam int N = 4;
  localparam int D = 512;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.NUM_REQ(N), .DEPTH(D)) bus ();

  mem_req_arbiter #(.NUM_REQ(N), .DEPTH(D), .SLOTS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic [2:0] exp_type;
    logic [3:0] exp_id;
  } vec_t;

  typedef struct {
    logic [1:0] who;
    logic       w;
  } ent_t;

  // reference model state
  ent_t        m_q[$];
  logic [1:0]  m_ptr;
  logic [3:0]  m_head, m_tail;
  int          m_st;
  logic        m_err;
  logic [3:0]  e_ready, e_id, e_rv;
  logic [2:0]  e_type;
  logic [35:0] e_addr, e_raddr;
  logic [D-1:0] e_data, e_rdata;
  logic        e_rw, e_fd;

  task automatic chk(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [D-1:0] rnd_wide();
    logic [D-1:0] r;
    r = '0;
    for (int k = 0; k < D / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid  = '0;
    bus.req_write  = '0;
    bus.flush      = 1'b0;
    bus.mc_type_in = 3'b000;
    bus.mc_id_in   = 4'd0;
    bus.mc_addr_in = '0;
    bus.mc_data_in = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i] = 36'(36'h100 * (i + 1));
      bus.req_data[i] = D'(i + 1);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    idle_inputs();
    bus.req_valid = 4'hf;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", D'(bus.req_ready), D'(4'h0));
    chk("rst_mc_type", D'(bus.mc_type_out), D'(3'b000));
    chk("rst_mc_id", D'(bus.mc_id_out), D'(4'd0));
    chk("rst_mc_addr", D'(bus.mc_addr_out), D'(36'd0));
    chk("rst_rsp_valid", D'(bus.rsp_valid), D'(4'h0));
    chk("rst_rsp_write", D'(bus.rsp_write), D'(1'b0));
    chk("rst_flush_done", D'(bus.flush_done), D'(1'b0));
    chk("rst_err_order", D'(bus.err_order), D'(1'b0));
    rst_n = 1'b1;
    bus.req_valid = '0;
    tick();
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ptr = '0; m_head = '0; m_tail = '0; m_st = 0; m_err = 1'b0;
    e_id = '0; e_type = '0; e_addr = '0; e_data = '0;
    e_rv = '0; e_rw = 1'b0; e_raddr = '0; e_rdata = '0; e_fd = 1'b0;
  endtask

  // one cycle of the reference: grant computed from the current inputs, registered outputs for after the edge
  task automatic model_step();
    int         qs0;
    logic       mf;
    logic [1:0] gsel;
    logic [1:0] c;
    ent_t       e;
    qs0  = m_q.size();
    mf   = 1'b0;
    gsel = '0;
    if (m_st == 0 && !bus.flush && qs0 < 16) begin
      for (int k = 0; k < N; k++) begin
        c = 2'((int'(m_ptr) + k) % N);
        if (!mf && bus.req_valid[c]) begin
          mf   = 1'b1;
          gsel = c;
        end
      end
    end
    e_ready = mf ? (4'b0001 << gsel) : 4'b0000;
    e_rv = 4'b0000;
    if (bus.mc_type_in == 3'b101 || bus.mc_type_in == 3'b110) begin
      if (qs0 > 0 && bus.mc_id_in == m_head) begin
        e       = m_q.pop_front();
        e_rv    = 4'b0001 << e.who;
        e_rw    = (bus.mc_type_in == 3'b101);
        e_raddr = bus.mc_addr_in;
        e_rdata = bus.mc_data_in;
        m_head  = m_head + 4'd1;
      end else begin
        m_err = 1'b1;
      end
    end
    e_type = 3'b000;
    if (mf) begin
      e.who  = gsel;
      e.w    = bus.req_write[gsel];
      m_q.push_back(e);
      e_id   = m_tail;
      m_tail = m_tail + 4'd1;
      e_type = e.w ? 3'b001 : 3'b011;
      e_addr = bus.req_addr[gsel];
      e_data = bus.req_data[gsel];
      m_ptr  = 2'((int'(gsel) + 1) % N);
    end
    e_fd = 1'b0;
    case (m_st)
      0: if (bus.flush) m_st = 1;
      1: if (qs0 == 0 && !mf) begin m_st = 2; e_fd = 1'b1; end
      default: if (!bus.flush) m_st = 0;
    endcase
  endtask

  vec_t tbl [9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [D-1:0] dval;
    logic [3:0]   seen;
    int           pulses;

    tbl[0] = '{4'b0101, 4'b0001, 3'b011, 4'd0};
    tbl[1] = '{4'b0101, 4'b0100, 3'b001, 4'd1};
    tbl[2] = '{4'b0101, 4'b0001, 3'b011, 4'd2};
    tbl[3] = '{4'b1111, 4'b0010, 3'b001, 4'd3};
    tbl[4] = '{4'b1111, 4'b0100, 3'b001, 4'd4};
    tbl[5] = '{4'b1111, 4'b1000, 3'b011, 4'd5};
    tbl[6] = '{4'b1010, 4'b0010, 3'b001, 4'd6};
    tbl[7] = '{4'b0000, 4'b0000, 3'b000, 4'd6};
    tbl[8] = '{4'b0011, 4'b0001, 3'b011, 4'd7};

    rst_n = 1'b0;
    idle_inputs();
    reset_dut();

    bus.req_write = 4'b0110;
    for (int i = 0; i < 9; i++) begin
      bus.req_valid = tbl[i].valid;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), D'(bus.req_ready), D'(tbl[i].exp_ready));
      tick();
      chk($sformatf("tbl%0d_type", i), D'(bus.mc_type_out), D'(tbl[i].exp_type));
      chk($sformatf("tbl%0d_id", i), D'(bus.mc_id_out), D'(tbl[i].exp_id));
    end

    // fill all 16 slots, then one response frees a slot
    reset_dut();
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("fill%0d_ready", k), D'(bus.req_ready), D'(4'b0100));
      tick();
    end
    @(negedge clk);
    chk("full_ready", D'(bus.req_ready), D'(4'b0000));
    dval = rnd_wide();
    bus.mc_type_in = 3'b110;
    bus.mc_id_in   = 4'd0;
    bus.mc_addr_in = 36'h9_1234_5678;
    bus.mc_data_in = dval;
    #1;
    chk("full_retire_ready", D'(bus.req_ready), D'(4'b0000));
    tick();
    bus.mc_type_in = 3'b000;
    chk("full_rsp_valid", D'(bus.rsp_valid), D'(4'b0100));
    chk("full_rsp_write", D'(bus.rsp_write), D'(1'b0));
    chk("full_rsp_addr", D'(bus.rsp_addr), D'(36'h9_1234_5678));
    chk("full_rsp_data", bus.rsp_data, dval);
    @(negedge clk);
    chk("full_resume_ready", D'(bus.req_ready), D'(4'b0100));
    tick();
    chk("full_resume_id", D'(bus.mc_id_out), D'(4'd0));
    chk("full_resume_type", D'(bus.mc_type_out), D'(3'b011));
    chk("full_rsp_pulse_end", D'(bus.rsp_valid), D'(4'b0000));

    // ignored type, out-of-order id, then the correct id; then a response after a mid-run reset
    reset_dut();
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid  = 4'b0000;
    bus.mc_type_in = 3'b011;
    bus.mc_id_in   = 4'd7;
    tick();
    chk("ignored_type_err", D'(bus.err_order), D'(1'b0));
    bus.mc_type_in = 3'b110;
    bus.mc_id_in   = 4'd5;
    tick();
    chk("ooo_err", D'(bus.err_order), D'(1'b1));
    chk("ooo_rsp_valid", D'(bus.rsp_valid), D'(4'b0000));
    bus.mc_id_in = 4'd0;
    tick();
    chk("ooo_head_kept", D'(bus.rsp_valid), D'(4'b1000));
    bus.mc_type_in = 3'b000;
    bus.req_valid  = 4'b0001;
    tick();
    bus.req_valid = 4'b0000;
    reset_dut();
    bus.mc_type_in = 3'b101;
    bus.mc_id_in   = 4'd0;
    tick();
    bus.mc_type_in = 3'b000;
    chk("post_reset_err", D'(bus.err_order), D'(1'b1));
    chk("post_reset_rsp_valid", D'(bus.rsp_valid), D'(4'b0000));

    // flush with three writes outstanding
    reset_dut();
    bus.req_write = 4'b1111;
    bus.req_valid = 4'b0010;
    repeat (3) tick();
    bus.flush     = 1'b1;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("flush_no_grant", D'(bus.req_ready), D'(4'b0000));
    tick();
    for (int a = 0; a < 3; a++) begin
      bus.mc_type_in = 3'b101;
      bus.mc_id_in   = 4'(a);
      tick();
      chk($sformatf("flush_ack%0d_valid", a), D'(bus.rsp_valid), D'(4'b0010));
      chk($sformatf("flush_ack%0d_write", a), D'(bus.rsp_write), D'(1'b1));
    end
    bus.mc_type_in = 3'b000;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.flush_done) pulses++;
    end
    chk("flush_done_pulses", D'(pulses), D'(1));
    bus.flush = 1'b0;
    seen = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      seen = bus.req_ready;
      if (seen != 4'b0000) break;
    end
    chk("flush_resume", D'(seen), D'(4'b0100));
    tick();

    // concurrent issue and response every cycle, across the id wrap
    reset_dut();
    bus.req_write = 4'b0000;
    bus.req_valid = 4'b0010;
    tick();
    for (int k = 1; k <= 20; k++) begin
      bus.mc_type_in = 3'b110;
      bus.mc_id_in   = 4'((k - 1) % 16);
      bus.mc_addr_in = 36'(k);
      @(negedge clk);
      chk($sformatf("pair%0d_ready", k), D'(bus.req_ready), D'(4'b0010));
      tick();
      chk($sformatf("pair%0d_id", k), D'(bus.mc_id_out), D'(k % 16));
      chk($sformatf("pair%0d_rsp", k), D'(bus.rsp_valid), D'(4'b0010));
      chk($sformatf("pair%0d_addr", k), D'(bus.rsp_addr), D'(k));
    end
    chk("pair_no_err", D'(bus.err_order), D'(1'b0));
    bus.mc_type_in = 3'b000;
    bus.req_valid  = 4'b0000;

    // randomized traffic against the reference model
    reset_dut();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int r;
      bus.req_valid = 4'($urandom);
      bus.req_write = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        bus.req_addr[i] = 36'({$urandom, $urandom});
        bus.req_data[i] = rnd_wide();
      end
      if (!bus.flush && ($urandom % 40) == 0) bus.flush = 1'b1;
      else if (bus.flush && ($urandom % 8) == 0) bus.flush = 1'b0;
      r = int'($urandom % 40);
      bus.mc_addr_in = 36'({$urandom, $urandom});
      bus.mc_data_in = rnd_wide();
      if (r < 16 && m_q.size() > 0) begin
        bus.mc_type_in = ($urandom % 2) ? 3'b101 : 3'b110;
        bus.mc_id_in   = m_head;
      end else if (r == 39) begin
        bus.mc_type_in = 3'($urandom);
        bus.mc_id_in   = 4'($urandom);
      end else begin
        bus.mc_type_in = (r % 3 == 0) ? 3'b011 : 3'b000;
        bus.mc_id_in   = 4'($urandom);
      end
      @(negedge clk);
      model_step();
      chk("rnd_req_ready", D'(bus.req_ready), D'(e_ready));
      tick();
      chk("rnd_mc_type", D'(bus.mc_type_out), D'(e_type));
      chk("rnd_mc_id", D'(bus.mc_id_out), D'(e_id));
      chk("rnd_mc_addr", D'(bus.mc_addr_out), D'(e_addr));
      chk("rnd_mc_data", bus.mc_data_out, e_data);
      chk("rnd_rsp_valid", D'(bus.rsp_valid), D'(e_rv));
      chk("rnd_rsp_write", D'(bus.rsp_write), D'(e_rw));
      chk("rnd_rsp_addr", D'(bus.rsp_addr), D'(e_raddr));
      chk("rnd_rsp_data", bus.rsp_data, e_rdata);
      chk("rnd_flush_done", D'(bus.flush_done), D'(e_fd));
      chk("rnd_err_order", D'(bus.err_order), D'(m_err));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
